// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between requesters/transmitter and the UART TX arbiter.
// master: environment side (req, req_data, tx_empty); slave: arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   tx_empty;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        grant;
  logic                   xmit_go;
  logic [DATA_W-1:0]      tx_data;
  logic                   busy;
  logic [CNT_W-1:0]       tx_count;

  modport master (
    output req, req_data, tx_empty,
    input  ack, grant, xmit_go, tx_data, busy, tx_count
  );

  modport slave (
    input  req, req_data, tx_empty,
    output ack, grant, xmit_go, tx_data, busy, tx_count
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NREQ requesters into one UART TX.
// Ports: clk, rst (async, active-high), bus (slave modport: req/req_data/
// tx_empty in; ack/grant/xmit_go/tx_data/busy/tx_count out, all registered).
module uart_tx_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    GUARD  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic [NREQ-1:0] win_oh;

  // Search starts one past the last winner and wraps; first set bit wins.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;

  // xmit_go is set together with ack so the strobe is visible during
  // LAUNCH; the byte counter steps on the edge that leaves LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IW'(NREQ - 1);
      bus.ack      <= '0;
      bus.grant    <= '0;
      bus.xmit_go  <= 1'b0;
      bus.tx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.tx_count <= '0;
    end else begin
      bus.ack     <= '0;
      bus.xmit_go <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_empty && found) begin
            state       <= LAUNCH;
            last        <= win;
            bus.ack     <= win_oh;
            bus.grant   <= win_oh;
            bus.xmit_go <= 1'b1;
            bus.busy    <= 1'b1;
            bus.tx_data <=
              bus.req_data[int'(win)*DATA_W +: DATA_W];
          end
        end
        LAUNCH: begin
          state        <= GUARD;
          bus.tx_count <= bus.tx_count + CNT_W'(1);
        end
        GUARD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.tx_empty) begin
            state     <= IDLE;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus corner
// sequences; a scoreboard queue matches every ack against expectations.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        te;
  logic        tie;
  logic [1:0]  wreq;

  uart_tx_arbiter_if #(.NREQ(4), .DATA_W(8), .CNT_W(16)) m ();
  uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  uart_tx_arbiter_if #(.NREQ(2), .DATA_W(8), .CNT_W(2)) w ();
  uart_tx_arbiter #(.NREQ(2), .DATA_W(8), .CNT_W(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (w)
  );

  assign m.req      = req;
  assign m.req_data = data;
  assign m.tx_empty = tie ? !m.xmit_go : te;
  assign w.req      = wreq;
  assign w.req_data = 16'hB1B0;
  assign w.tx_empty = !w.xmit_go;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] ack;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  always @(posedge clk) begin
    #1;
    if (!rst && m.ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(m.ack), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", 32'(m.ack), 32'(e.ack));
        chk("sb_data", 32'(m.tx_data), 32'(e.data));
        chk("sb_go", 32'(m.xmit_go), 32'h1);
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ack"}, 32'(m.ack), 0);
    chk({nm, "_grant"}, 32'(m.grant), 0);
    chk({nm, "_go"}, 32'(m.xmit_go), 0);
    chk({nm, "_busy"}, 32'(m.busy), 0);
    chk({nm, "_txd"}, 32'(m.tx_data), 0);
    chk({nm, "_cnt"}, 32'(m.tx_count), 0);
  endtask

  task automatic txn(input logic [3:0] r, input logic [31:0] d,
                     input logic [3:0] ea, input logic [7:0] ed,
                     input string nm);
    te   = 1'b1;
    req  = r;
    data = d;
    sb.push_back('{ea, ed});
    step();
    chk({nm, "_go"}, 32'(m.xmit_go), 1);
    chk({nm, "_grant"}, 32'(m.grant), 32'(ea));
    chk({nm, "_busy"}, 32'(m.busy), 1);
    req  = 4'b0000;
    data = 32'hDEADBEEF;
    te   = 1'b0;
    step();
    cnt_exp++;
    chk({nm, "_go_off"}, 32'(m.xmit_go), 0);
    chk({nm, "_ack_off"}, 32'(m.ack), 0);
    chk({nm, "_grant_hold"}, 32'(m.grant), 32'(ea));
    chk({nm, "_txd_hold"}, 32'(m.tx_data), 32'(ed));
    chk({nm, "_cnt"}, 32'(m.tx_count), 32'(cnt_exp));
    step();
    te = 1'b1;
    step();
    chk({nm, "_grant_clr"}, 32'(m.grant), 0);
    chk({nm, "_idle"}, 32'(m.busy), 0);
    chk({nm, "_txd_keep"}, 32'(m.tx_data), 32'(ed));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int t[$];
    int cyc;
    int strobes;
    int n;
    bit ok;

    tbl[0] = '{4'b0001, 32'h44434241, 4'b0001, 8'h41};
    tbl[1] = '{4'b1111, 32'h13121110, 4'b0010, 8'h11};
    tbl[2] = '{4'b1111, 32'h23222120, 4'b0100, 8'h22};
    tbl[3] = '{4'b1111, 32'h33323130, 4'b1000, 8'h33};
    tbl[4] = '{4'b1111, 32'h43424140, 4'b0001, 8'h40};
    tbl[5] = '{4'b1001, 32'h53525150, 4'b1000, 8'h53};
    tbl[6] = '{4'b0011, 32'h63626160, 4'b0001, 8'h60};
    tbl[7] = '{4'b0001, 32'h73727170, 4'b0001, 8'h70};
    tbl[8] = '{4'b1000, 32'h83828180, 4'b1000, 8'h83};
    tbl[9] = '{4'b0110, 32'h93929190, 4'b0010, 8'h91};

    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;
    te   = 1'b1;
    tie  = 1'b0;
    wreq = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Idle with no request, then request while transmitter is busy.
    ok = 1'b1;
    repeat (3) begin
      step();
      if (m.xmit_go !== 1'b0 || m.busy !== 1'b0) ok = 1'b0;
    end
    chk("idle_noreq", 32'(ok), 1);
    req = 4'b0001;
    te  = 1'b0;
    ok  = 1'b1;
    repeat (3) begin
      step();
      if (m.xmit_go !== 1'b0 || m.busy !== 1'b0) ok = 1'b0;
    end
    chk("idle_txbusy", 32'(ok), 1);

    foreach (tbl[i])
      txn(tbl[i].req, tbl[i].data, tbl[i].ack, tbl[i].txd,
          $sformatf("vec%0d", i));

    // Fairness with all four requesting and tx_empty = !xmit_go.
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_exp = 0;
    tie  = 1'b1;
    data = 32'hA3A2A1A0;
    sb.push_back('{4'b0001, 8'hA0});
    sb.push_back('{4'b0010, 8'hA1});
    sb.push_back('{4'b0100, 8'hA2});
    sb.push_back('{4'b1000, 8'hA3});
    sb.push_back('{4'b0001, 8'hA0});
    req = 4'b1111;
    cyc = 0;
    strobes = 0;
    while (strobes < 5 && cyc < 40) begin
      step();
      cyc++;
      if (m.xmit_go === 1'b1) begin
        t.push_back(cyc);
        strobes++;
        if (strobes == 5) req = 4'b0000;
      end
    end
    chk("fair_strobes", 32'(strobes), 5);
    chk("fair_latency", (t.size() > 0) ? 32'(t[0]) : 32'hFFFF, 1);
    for (int i = 1; i < t.size(); i++)
      chk($sformatf("fair_gap%0d", i), 32'(t[i] - t[i-1]), 4);
    cnt_exp += strobes;
    repeat (4) step();
    tie = 1'b0;
    te  = 1'b1;
    chk("fair_cnt", 32'(m.tx_count), 5);
    chk("fair_idle", 32'(m.busy), 0);

    // Back-pressure: transmitter stays busy for 20 cycles.
    req  = 4'b0100;
    data = 32'hC3C2C1C0;
    sb.push_back('{4'b0100, 8'hC2});
    step();
    chk("bp_go", 32'(m.xmit_go), 1);
    req = 4'b0000;
    te  = 1'b0;
    cnt_exp++;
    ok = 1'b1;
    repeat (20) begin
      step();
      if (m.busy !== 1'b1 || m.grant !== 4'b0100 || m.xmit_go !== 1'b0)
        ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 1);
    chk("bp_cnt", 32'(m.tx_count), 32'(cnt_exp));
    te = 1'b1;
    step();
    chk("bp_release_busy", 32'(m.busy), 0);
    chk("bp_release_grant", 32'(m.grant), 0);

    // Reset in WAIT: aborts, priority returns to requester 0.
    req  = 4'b0100;
    data = 32'hE3E2E1E0;
    sb.push_back('{4'b0100, 8'hE2});
    step();
    req = 4'b0000;
    te  = 1'b0;
    step();
    step();
    chk("rw_grant", 32'(m.grant), 32'h4);
    chk("rw_busy", 32'(m.busy), 1);
    rst = 1'b1;
    #1;
    check_zero("rw_async");
    step();
    rst = 1'b0;
    cnt_exp = 0;
    req  = 4'b0101;
    data = 32'hF3F2F1F0;
    te   = 1'b1;
    sb.push_back('{4'b0001, 8'hF0});
    step();
    chk("rw_regrant_go", 32'(m.xmit_go), 1);
    chk("rw_regrant", 32'(m.grant), 32'h1);
    req = 4'b0000;
    te  = 1'b0;
    step();
    cnt_exp++;
    chk("rw_cnt", 32'(m.tx_count), 32'(cnt_exp));
    step();
    te = 1'b1;
    step();

    // Skipped requester: last=1, requester 2 drops before selection.
    txn(4'b0010, 32'h57565554, 4'b0010, 8'h55, "skip_pre");
    te  = 1'b0;
    req = 4'b0110;
    repeat (3) step();
    chk("skip_wait_ack", 32'(m.ack), 0);
    chk("skip_wait_go", 32'(m.xmit_go), 0);
    req  = 4'b0010;
    data = 32'h67666564;
    te   = 1'b1;
    sb.push_back('{4'b0010, 8'h65});
    step();
    chk("skip_grant", 32'(m.grant), 32'h2);
    req = 4'b0000;
    te  = 1'b0;
    step();
    step();
    te = 1'b1;
    repeat (3) step();

    // Counter wrap on the 2-bit counter instance.
    wreq = 2'b11;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      step();
      cyc++;
      if (w.xmit_go === 1'b1) begin
        n++;
        chk($sformatf("wrap_ack%0d", n), 32'(w.ack),
            (n % 2 == 1) ? 32'h1 : 32'h2);
        chk($sformatf("wrap_txd%0d", n), 32'(w.tx_data),
            (n % 2 == 1) ? 32'hB0 : 32'hB1);
        chk($sformatf("wrap_pre%0d", n), 32'(w.tx_count),
            32'((n - 1) % 4));
        if (n == 4) wreq = 2'b00;
      end
    end
    chk("wrap_launches", 32'(n), 4);
    step();
    chk("wrap_cnt", 32'(w.tx_count), 0);

    repeat (4) step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DATA_W, default 8, SHALL set the byte width passed to the transmitter.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the transmitted-byte counter.
REQ-004 Enable  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 Reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 Req  in  NREQ  SHALL carry per-requester level requests; bit i high means ReqData slice i holds a byte to send.
REQ-007 ReqData  in  NREQ*DATA_W  SHALL carry requester i's byte in bits [i*DATA_W +: DATA_W].
REQ-008 TxEmpty  in  1  SHALL be the transmitter idle flag; high means ready for a new byte.
REQ-009 Ack  out  NREQ  SHALL pulse one cycle, one-hot, when the requester's byte is latched.
REQ-010 Grant  out  NREQ  SHALL be one-hot for the owning requester from launch until the transmitter returns idle, else zero.
REQ-011 XMitGo  out  1  SHALL be the one-cycle transmit-start strobe to the transmitter.
REQ-012 TxData  out  DATA_W  SHALL hold the latched byte, stable from the XMitGo cycle until the next launch.
REQ-013 Busy  out  1  SHALL be high in every state except IDLE.
REQ-014 TxCount  out  CNT_W  SHALL count XMitGo strobes issued since reset.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, GUARD and WAIT, registered and fully encoded; illegal encodings SHALL return to IDLE.
REQ-016 IDLE: when TxEmpty=1 and Req!=0, the arbiter SHALL select a winner, latch its ReqData slice into TxData, pulse Ack[winner] and move to LAUNCH the same edge.
REQ-017 IDLE with TxEmpty=0 or Req=0 SHALL remain in IDLE with Ack=0 and XMitGo=0.
REQ-018 The winner SHALL be chosen round-robin: search starts at (Last+1) mod NREQ, wraps, and takes the first set Req bit; Last SHALL update to the winner on each grant.
REQ-019 LAUNCH SHALL last exactly one cycle with XMitGo=1 and then go to GUARD; TxCount SHALL increment by 1 on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-020 GUARD SHALL last exactly one cycle, ignore TxEmpty and then go to WAIT.
REQ-021 WAIT SHALL remain until TxEmpty=1 is sampled and then go to IDLE; no new grant SHALL be issued in that same edge.
REQ-022 Latency: from a Req sampled in IDLE with TxEmpty=1, XMitGo SHALL assert on the next cycle; the minimum spacing between consecutive XMitGo strobes SHALL be 4 cycles.
REQ-023 Req changes after Ack SHALL NOT affect TxData or Grant for the transaction in flight.
REQ-024 A requester dropping Req before being granted SHALL lose its turn without side effects; Ack SHALL never pulse for a requester whose Req was low at selection.
REQ-025 With a single active requester, it SHALL be granted on every IDLE opportunity.
REQ-026 Ack, Grant and XMitGo SHALL be registered outputs with no combinational path from Req or TxEmpty.

Reset
REQ-027 Reset=1 SHALL immediately force state IDLE, XMitGo=0, Ack=0, Grant=0, Busy=0, TxData=0, TxCount=0 and Last=NREQ-1, so requester 0 has first priority.
REQ-028 Reset asserted mid-transaction SHALL abort it without an Ack or XMitGo pulse after release; an aborted byte is not retried.
REQ-029 After Reset is released, the first grant SHALL occur no earlier than the first rising edge of Enable with TxEmpty=1.

Verification
REQ-030 Single request: Req=4'b0001, ReqData[7:0]=8'h41, TxEmpty=1 -> Ack=0001 and transition to LAUNCH on edge 1; XMitGo=1, TxData=8'h41 in cycle 2; TxCount=1.
REQ-031 Fairness: Req=4'b1111 held, TxEmpty tied to !XMitGo -> grant order 0,1,2,3,0 with XMitGo strobes exactly 4 cycles apart.
REQ-032 Back-pressure: TxEmpty held 0 for 20 cycles after launch -> state stays WAIT, Busy=1, Grant is unchanged, no further XMitGo; TxEmpty=1 -> IDLE on the next edge.
REQ-033 Wrap: preload TxCount to 16'hFFFF through forced stimulus, issue one launch -> TxCount=16'h0000.
REQ-034 Reset mid-WAIT: Reset pulsed while Grant=0100 -> all outputs are zero at once; next grant goes to requester 0 when Req=4'b0101.
REQ-035 Skipped requester: Req=4'b0110 with Last=1, requester 2 drops Req before selection -> requester 1 is granted and Ack[2] never pulses.
